// File: rtl/irq_arb_pkg.sv
// Shared types and helpers for the pending-interrupt arbiter.
// Define IRQ_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
package irq_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic {
        StIdle,
        StGrant
    } arb_state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational picker: rotate candidates by ptr, take the lowest set bit, rotate back.
module rr_pick
    import irq_arb_pkg::*;
(
    input  logic [N_REQ-1:0] cand_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] pick_onehot_o,
    output logic             pick_vld_o
);

    logic [2*N_REQ-1:0] rot_dbl;
    logic [2*N_REQ-1:0] back_dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   first;

    always_comb begin
        rot_dbl       = {cand_i, cand_i} >> ptr_i;
        rot           = rot_dbl[N_REQ-1:0];
        // Two's-complement trick isolates the lowest set bit.
        first         = rot & (~rot + 1'b1);
        back_dbl      = {first, first} << ptr_i;
        pick_onehot_o = back_dbl[2*N_REQ-1:N_REQ];
        pick_vld_o    = |cand_i;
    end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Edge-captured sticky pending bits arbitrated into a registered one-hot grant (valid/ready).
// IRQ_ARB_ROUND_ROBIN_EN selects round-robin; undefined gives fixed lowest-index priority.
module irq_pending_arbiter
    import irq_arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [N_REQ-1:0] grant_onehot_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic [N_REQ-1:0] pending_o,
    output logic             ovf_o
);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] req_q;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;

    logic [N_REQ-1:0] events, clear, cand, pick_onehot;
    logic [IDX_W-1:0] search_ptr;
    logic             accept, pick_vld;

    assign accept    = (state_q == StGrant) && ready_i;
    assign events    = req_i & ~req_q;
    assign clear     = accept ? grant_q : '0;
    assign cand      = pending_q & ~clear;
    assign pending_d = cand | events;
    assign ovf_d     = |(events & cand);

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign ptr_d = accept ? idx_q + IDX_W'(1) : ptr_q;
    // Search from the updated pointer so the next grant rotates past the one just accepted.
    assign search_ptr = ptr_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign search_ptr = '0;
`endif

    rr_pick u_rr_pick (
        .cand_i        (cand),
        .ptr_i         (search_ptr),
        .pick_onehot_o (pick_onehot),
        .pick_vld_o    (pick_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        // A presented grant holds until accepted; idle loads whenever something is pending.
        if (state_q == StIdle || ready_i) begin
            if (pick_vld) begin
                state_d = StGrant;
                grant_d = pick_onehot;
                idx_d   = onehot_to_idx(pick_onehot);
            end else begin
                state_d = StIdle;
                grant_d = '0;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            req_q     <= '0;
            pending_q <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
        end
    end

    assign valid_o        = (state_q == StGrant);
    assign grant_onehot_o = grant_q;
    assign grant_idx_o    = idx_q;
    assign pending_o      = pending_q;
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// Self-checking bench for irq_pending_arbiter: directed scenarios plus randomized run vs a model.
module tb_irq_pending_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       ready = 1'b0;
    logic       valid;
    logic [7:0] grant_onehot;
    logic [2:0] grant_idx;
    logic [7:0] pending;
    logic       ovf;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [7:0] m_req, m_pend;
    logic       m_valid, m_ovf;
    int         m_idx, m_ptr;

    irq_pending_arbiter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .ready_i        (ready),
        .valid_o        (valid),
        .grant_onehot_o (grant_onehot),
        .grant_idx_o    (grant_idx),
        .pending_o      (pending),
        .ovf_o          (ovf)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_req = 8'h00; m_pend = 8'h00; m_valid = 1'b0; m_ovf = 1'b0; m_idx = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        logic [7:0] ev, clr, cand;
        int start, pick;
        ev = req & ~m_req;
        clr = (m_valid && ready) ? (8'h01 << m_idx) : 8'h00;
        cand = m_pend & ~clr;
        m_ovf = |(ev & cand);
        if (m_valid && ready) m_ptr = (m_idx + 1) % 8;
        if (!(m_valid && !ready)) begin
`ifdef IRQ_ARB_ROUND_ROBIN_EN
            start = m_ptr;
`else
            start = 0;
`endif
            pick = -1;
            for (int k = 0; k < 8; k++) begin
                if (pick < 0 && cand[(start + k) % 8]) pick = (start + k) % 8;
            end
            m_valid = (pick >= 0);
            m_idx = (pick >= 0) ? pick : 0;
        end
        m_pend = cand | ev;
        m_req = req;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 8'h00; ready = 1'b0;
        #2;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (grant_onehot !== 8'h00) begin bad++; $display("FAIL reset_oh got=%h want=00", grant_onehot); end
        total++; if (grant_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", grant_idx); end
        total++; if (pending !== 8'h00) begin bad++; $display("FAIL reset_pend got=%h want=00", pending); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        cycle();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_idle got=%b want=0", valid); end
    endtask

    task automatic test_single();
        do_reset();
        req = 8'h10; cycle();
        total++; if (pending !== 8'h10 || valid !== 1'b0) begin bad++;
            $display("FAIL single_pend got=%h/%b want=10/0", pending, valid); end
        req = 8'h00; cycle();
        total++; if (valid !== 1'b1 || grant_onehot !== 8'h10 || grant_idx !== 3'd4) begin bad++;
            $display("FAIL single_grant got=%b/%h/%0d want=1/10/4", valid, grant_onehot, grant_idx); end
        ready = 1'b1; cycle();
        total++; if (valid !== 1'b0 || pending !== 8'h00 || grant_onehot !== 8'h00) begin bad++;
            $display("FAIL single_done got=%b/%h/%h want=0/00/00", valid, pending, grant_onehot); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready = 1'b1; req = 8'h81; cycle();
        req = 8'h00; cycle();
        total++; if (valid !== 1'b1 || grant_idx !== 3'd0) begin bad++;
            $display("FAIL b2b_first got=%b/%0d want=1/0", valid, grant_idx); end
        cycle();
        total++; if (valid !== 1'b1 || grant_idx !== 3'd7 || grant_onehot !== 8'h80) begin bad++;
            $display("FAIL b2b_second got=%b/%0d/%h want=1/7/80", valid, grant_idx, grant_onehot); end
        cycle();
        total++; if (valid !== 1'b0 || pending !== 8'h00) begin bad++;
            $display("FAIL b2b_idle got=%b/%h want=0/00", valid, pending); end
    endtask

    task automatic test_hold();
        do_reset();
        req = 8'h08; cycle();
        req = 8'h00; cycle();
        req = 8'h02; cycle();
        req = 8'h00; cycle();
        total++; if (valid !== 1'b1 || grant_idx !== 3'd3 || pending !== 8'h0A) begin bad++;
            $display("FAIL hold_stable got=%b/%0d/%h want=1/3/0a", valid, grant_idx, pending); end
        ready = 1'b1; cycle();
        total++; if (valid !== 1'b1 || grant_idx !== 3'd1 || pending !== 8'h02) begin bad++;
            $display("FAIL hold_next got=%b/%0d/%h want=1/1/02", valid, grant_idx, pending); end
        cycle();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL hold_idle got=%b want=0", valid); end
    endtask

    task automatic test_ovf();
        int ovf_seen = 0;
        do_reset();
        req = 8'h04; cycle();
        req = 8'h00; cycle();
        req = 8'h04; cycle();
        ovf_seen += int'(ovf);
        req = 8'h00; cycle();
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_pulse_len got=%b want=0", ovf); end
        ovf_seen += int'(ovf);
        total++; if (ovf_seen != 1) begin bad++; $display("FAIL ovf_count got=%0d want=1", ovf_seen); end
        ready = 1'b1; cycle();
        total++; if (valid !== 1'b0 || pending !== 8'h00) begin bad++;
            $display("FAIL ovf_single_grant got=%b/%h want=0/00", valid, pending); end
    endtask

    task automatic test_repend();
        do_reset();
        req = 8'h20; cycle();
        req = 8'h00; cycle();
        ready = 1'b1; req = 8'h20; cycle();
        total++; if (pending !== 8'h20 || ovf !== 1'b0 || valid !== 1'b0) begin bad++;
            $display("FAIL repend_set got=%h/%b/%b want=20/0/0", pending, ovf, valid); end
        req = 8'h00; cycle();
        total++; if (valid !== 1'b1 || grant_idx !== 3'd5) begin bad++;
            $display("FAIL repend_regrant got=%b/%0d want=1/5", valid, grant_idx); end
        cycle();
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 8'hFF; cycle();
        req = 8'h00; cycle();
        total++; if (valid !== 1'b1 || pending !== 8'hFF) begin bad++;
            $display("FAIL midrst_pre got=%b/%h want=1/ff", valid, pending); end
        #1; rst = 1'b1; req = 8'h02; #1;
        model_reset();
        total++; if ({valid, grant_onehot, grant_idx, pending, ovf} !== 21'd0) begin bad++;
            $display("FAIL midrst_async got=%b/%h/%0d/%h/%b want=all0",
                     valid, grant_onehot, grant_idx, pending, ovf); end
        @(negedge clk); rst = 1'b0;
        cycle();
        total++; if (pending !== 8'h02 || valid !== 1'b0) begin bad++;
            $display("FAIL midrst_pend got=%h/%b want=02/0", pending, valid); end
        cycle();
        total++; if (valid !== 1'b1 || grant_idx !== 3'd1) begin bad++;
            $display("FAIL midrst_grant got=%b/%0d want=1/1", valid, grant_idx); end
        req = 8'h00;
    endtask

    task automatic test_random();
        logic [7:0] exp_oh;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            req = 8'($urandom) & 8'($urandom) & 8'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            cycle();
            exp_oh = m_valid ? (8'h01 << m_idx) : 8'h00;
            total++; if (valid !== m_valid) begin bad++;
                $display("FAIL rnd_valid c=%0d got=%b want=%b", c, valid, m_valid); end
            total++; if (grant_onehot !== exp_oh) begin bad++;
                $display("FAIL rnd_oh c=%0d got=%h want=%h", c, grant_onehot, exp_oh); end
            total++; if (grant_idx !== 3'(m_idx)) begin bad++;
                $display("FAIL rnd_idx c=%0d got=%0d want=%0d", c, grant_idx, m_idx); end
            total++; if (pending !== m_pend) begin bad++;
                $display("FAIL rnd_pend c=%0d got=%h want=%h", c, pending, m_pend); end
            total++; if (ovf !== m_ovf) begin bad++;
                $display("FAIL rnd_ovf c=%0d got=%b want=%b", c, ovf, m_ovf); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_hold();
        test_ovf();
        test_repend();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
